// File: rtl/pq_pkg.sv
// pq_pkg: shared FSM state and command encodings for the priority-queue stream driver.
package pq_pkg;
  typedef enum logic [1:0] {DRV_IDLE, DRV_ISSUE, DRV_GAP} drv_state_t;
  typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_REPL} pq_op_t;
endpackage

// File: rtl/pq_out_fifo.sv
// pq_out_fifo: power-of-two synchronous FIFO holding popped keys behind a valid/ready head.
module pq_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end
  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = count_q == '0;
  assign count   = count_q;
  // Credit accounting upstream guarantees a free slot for every tagged read.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && !rd_en && count_q == CW'(DEPTH)));
endmodule

// File: rtl/pq_stream_driver.sv
// pq_stream_driver: turns a push stream and pop enable into spaced heap-queue commands.
// Define PQ_DRV_REPLACE_EN to merge a simultaneous push and pop into one replace command.
module pq_stream_driver
  import pq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int QUEUE_SIZE = 7,
  parameter int OP_GAP     = 4,
  parameter int RD_LAT     = 2,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                            CLK,
  input  logic                            RSTn,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_WIDTH-1:0]           s_data,
  input  logic                            pop_en,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            pq_wrt,
  output logic                            pq_read,
  output logic [DATA_WIDTH-1:0]           pq_data,
  input  logic                            pq_full,
  input  logic                            pq_empty,
  input  logic [DATA_WIDTH-1:0]           pq_dout,
  output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
  output logic                            o_err
);
  localparam int CW = $clog2(QUEUE_SIZE+1);
  localparam int GW = $clog2(OP_GAP+1);
  localparam int FW = $clog2(OUT_DEPTH+1);
  drv_state_t state_q, state_d;
  pq_op_t op_d;
  logic [CW-1:0] count_q, count_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [FW-1:0] inflight_q, inflight_d, fifo_cnt;
  logic [RD_LAT-1:0] rd_sr_q, rd_sr_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic wrt_q, wrt_d, read_q, read_d, last_push_q, last_push_d, err_q, err_d;
  logic push_ok, pop_ok, tag_exit, fifo_empty;
  assign push_ok  = state_q == DRV_IDLE && s_valid && count_q < CW'(QUEUE_SIZE);
  assign pop_ok   = state_q == DRV_IDLE && pop_en && count_q != '0 &&
                    int'(fifo_cnt) + int'(inflight_q) < OUT_DEPTH;
  assign tag_exit = rd_sr_q[RD_LAT-1];
  always_comb begin
`ifdef PQ_DRV_REPLACE_EN
    op_d = push_ok && pop_ok ? OP_REPL : push_ok ? OP_PUSH : pop_ok ? OP_POP : OP_NONE;
`else
    op_d = push_ok && pop_ok ? (last_push_q ? OP_POP : OP_PUSH) :
           push_ok ? OP_PUSH : pop_ok ? OP_POP : OP_NONE;
`endif
    s_ready     = op_d == OP_PUSH || op_d == OP_REPL;
    read_d      = op_d == OP_POP || op_d == OP_REPL;
    wrt_d       = s_ready;
    key_d       = s_ready ? s_data : key_q;
    count_d     = op_d == OP_PUSH ? count_q + CW'(1) : op_d == OP_POP ? count_q - CW'(1) : count_q;
    last_push_d = op_d == OP_PUSH ? 1'b1 : op_d == OP_POP ? 1'b0 : last_push_q;
    inflight_d  = inflight_q + FW'(read_d) - FW'(tag_exit);
    rd_sr_d     = (rd_sr_q << 1) | RD_LAT'(read_q);
    // A replace writes into a full queue legitimately, so only a plain push is flagged.
    err_d       = err_q | (wrt_q & ~read_q & pq_full) | (read_q & pq_empty);
    state_d     = state_q;
    gap_d       = gap_q;
    case (state_q)
      DRV_IDLE:  state_d = op_d != OP_NONE ? DRV_ISSUE : DRV_IDLE;
      DRV_ISSUE: begin
        state_d = OP_GAP > 1 ? DRV_GAP : DRV_IDLE;
        gap_d   = GW'(1);
      end
      DRV_GAP: begin
        state_d = gap_q >= GW'(OP_GAP - 1) ? DRV_IDLE : DRV_GAP;
        gap_d   = gap_q + GW'(1);
      end
      default: state_d = DRV_IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      state_q     <= DRV_IDLE;
      count_q     <= '0;
      gap_q       <= '0;
      inflight_q  <= '0;
      rd_sr_q     <= '0;
      key_q       <= '0;
      wrt_q       <= 1'b0;
      read_q      <= 1'b0;
      last_push_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      inflight_q  <= inflight_d;
      rd_sr_q     <= rd_sr_d;
      key_q       <= key_d;
      wrt_q       <= wrt_d;
      read_q      <= read_d;
      last_push_q <= last_push_d;
      err_q       <= err_d;
    end
  pq_out_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(DATA_WIDTH)) u_out_fifo (
    .clk     (CLK),
    .rst_n   (RSTn),
    .wr_en   (tag_exit),
    .wr_data (pq_dout),
    .rd_en   (m_valid & m_ready),
    .rd_data (m_data),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );
  assign m_valid = ~fifo_empty;
  assign pq_wrt  = wrt_q;
  assign pq_read = read_q;
  assign pq_data = key_q;
  assign o_count = count_q;
  assign o_err   = err_q;
endmodule
